hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage RISC-V core. Sits beside the IF/ID/EX/MEM/WB pipeline registers.
- Generates the EX-stage forwarding selects that drive the 3:1 operand muxes.
- Generates load-use stalls, branch/jump flushes, and data-memory wait-state stalls with a timeout FSM.
- Keeps saturating stall and flush performance counters.

Parameters:
- CNT_W, 16, width of StallCycles and FlushCount.
- MEM_TIMEOUT, 8, number of consecutive stalled memory-wait cycles before a fault (must be ≥2).
- TO_W, 4, width of the internal wait counter (must satisfy 2^TO_W > MEM_TIMEOUT).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Rs1D, Rs2D  in  5 each  source register numbers in Decode.
- Rs1E, Rs2E  in  5 each  source register numbers in Execute.
- RdE, RdM, RdW  in  5 each  destination register numbers in E, M, W.
- ResultSrcE  in  2  result select in E; 2'b01 marks a load.
- RegWriteM, RegWriteW  in  1 each  register-write enables in M and W.
- PCSrcE  in  1  branch taken or jump resolved in E.
- MemReqM  in  1  load or store present in M.
- MemAckM  in  1  data memory completes the access this cycle.
- ForwardAE, ForwardBE  out  2 each  operand mux select: 00 = register file, 01 = ResultW, 10 = ALUResultM.
- StallF, StallD, StallE, StallM  out  1 each  hold the corresponding pipeline register.
- FlushD, FlushE, FlushW  out  1 each  load a bubble into the corresponding pipeline register.
- MemErr  out  1  sticky memory-timeout fault.
- StallCycles  out  CNT_W  count of cycles with any stall asserted.
- FlushCount  out  CNT_W  count of cycles with a taken control flush.

Behaviour:
- Reset (synchronous, active-high):
  - On a clk edge with reset=1: state←IDLE, WaitCnt←0, MemErr←0, StallCycles←0, FlushCount←0.
  - While reset=1, outputs are: Forward* = 00, all Stall* = 0, FlushD/E/W = 1.
  - Reset mid-wait or in ERROR returns to IDLE at that edge.
- Forwarding (combinational, per operand; shown for A, B identical using Rs2E):
  - 10 if RegWriteM && RdM!=0 && RdM==Rs1E;
  - else 01 if RegWriteW && RdW!=0 && RdW==Rs1E;
  - else 00.
  - M has priority over W. x0 is never forwarded.
- Load-use hazard: lwStall = (ResultSrcE==2'b01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- Memory stall: memStall = (state!=ERROR) && MemReqM && !MemAckM.
- Memory FSM (registered):
  - IDLE: if memStall → WAIT with WaitCnt←1.
  - WAIT:
    - if !memStall → IDLE, WaitCnt←0;
    - else if WaitCnt==MEM_TIMEOUT-1 → ERROR, MemErr←1;
    - else WaitCnt←WaitCnt+1.
  - ERROR: held until reset. MemErr=1.
- Output priority: ERROR > memStall > lwStall/PCSrcE.
  - ERROR: all Stall*=1, FlushW=1, FlushD=FlushE=0.
  - memStall: StallF/D/E/M=1, FlushW=1, FlushD=FlushE=0. Load-use and branch flush are suppressed. The frozen E stage keeps PCSrcE/lwStall pending; they act in the first cycle after release.
  - Otherwise:
    - StallF=StallD=lwStall;
    - FlushD=PCSrcE;
    - FlushE=lwStall|PCSrcE;
    - StallE=StallM=FlushW=0.
- A load-use and a taken branch in the same cycle: both apply (F/D stalled, E flushed, D flushed).
- MemAckM in the same cycle as MemReqM: no stall, zero added latency.
- Counters (registered, saturate at all-ones, no wrap):
  - StallCycles increments on each edge where any Stall* output is 1.
  - FlushCount increments on each edge where FlushD=1 due to PCSrcE (not during reset).

Test Plan:
- Forwarding: RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5, Rs2E=0 → ForwardAE=10, ForwardBE=00. Then RegWriteM=0 → ForwardAE=01. Then RdW=0, Rs1E=0 → 00.
- Load-use: ResultSrcE=01, RdE=3, Rs2D=3 for one cycle → StallF=StallD=FlushE=1, FlushD=0, StallCycles 0→1. With RdE=0 → no stall.
- Branch: PCSrcE=1 for one cycle → FlushD=FlushE=1, stalls 0, FlushCount 0→1. Concurrent load-use → StallF=StallD=FlushD=FlushE=1.
- Memory wait: MemReqM=1, MemAckM low 3 cycles then high → StallF/D/E/M=FlushW=1 for exactly 3 cycles, 0 in the ack cycle. State returns to IDLE. StallCycles=3. PCSrcE=1 held during the wait → FlushD=1 only in the ack cycle.
- Timeout: MEM_TIMEOUT=8, MemReqM=1, MemAckM=0 → MemErr=1 after the 8th stalled edge, all stalls stay 1. Ack on cycle 8 instead → no error. Reset pulse → MemErr=0, counters 0, stalls released.
- Saturation: CNT_W=4, hold lwStall 20 cycles → StallCycles stops at 15. Reset during reset-high cycles → FlushD/E/W=1, Forward*=00.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage RISC-V core.
// It produces the EX-stage operand forwarding selects. It detects load-use
// hazards and control-flow flushes, and freezes the pipeline while the data
// memory inserts wait states. If the memory keeps the pipeline frozen too
// long, a timeout FSM latches a sticky fault that only reset clears.
// Saturating counters record stall cycles and taken-control flushes.
module hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 8,
    parameter int TO_W        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [1:0]       ResultSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemAckM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    // States of the data-memory wait tracker.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        ERROR = 2'b10
    } mem_state_t;

    // Encodings of the EX operand mux select.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // A ResultSrcE value of 01 marks the instruction in Execute as a load.
    localparam logic [1:0] RESULT_LOAD = 2'b01;

    localparam logic [TO_W-1:0]  WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    mem_state_t      state;
    mem_state_t      state_next;
    logic [TO_W-1:0] wait_cnt;
    logic [TO_W-1:0] wait_cnt_next;
    logic            mem_err_q;
    logic            mem_err_next;

    logic            lw_stall;
    logic            mem_stall;
    logic            any_stall;
    logic            branch_flush;

    // Hazard detection. A load in Execute whose destination feeds either
    // Decode source cannot forward in time, so Decode must wait a cycle.
    // Writes to x0 are ignored because x0 is hard-wired to zero. A pending
    // memory access that is not acknowledged this cycle freezes the pipeline.
    // Once the fault is latched, the frozen state comes from ERROR and no
    // longer from the handshake.
    always_comb begin
        lw_stall  = (ResultSrcE == RESULT_LOAD) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));
        mem_stall = (state != ERROR) && MemReqM && !MemAckM;
    end

    // Forwarding selects for both EX operands. The Memory stage holds the
    // youngest result, so it takes priority over Writeback. During reset the
    // muxes fall back to the register file so nothing stale is injected.
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (!reset) begin
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E)) begin
                ForwardAE = FWD_MEM;
            end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) begin
                ForwardAE = FWD_WB;
            end
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E)) begin
                ForwardBE = FWD_MEM;
            end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) begin
                ForwardBE = FWD_WB;
            end
        end
    end

    // Next-state logic of the memory wait tracker. The counter holds the
    // number of stalled edges already taken. When the last allowed stalled
    // cycle still sees no acknowledge, the FSM latches the fault instead of
    // waiting any longer.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        mem_err_next  = mem_err_q;
        unique case (state)
            IDLE: begin
                if (mem_stall) begin
                    state_next    = WAIT;
                    wait_cnt_next = TO_W'(1);
                end
            end
            WAIT: begin
                if (!mem_stall) begin
                    state_next    = IDLE;
                    wait_cnt_next = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next   = ERROR;
                    mem_err_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt + TO_W'(1);
                end
            end
            ERROR: begin
                state_next   = ERROR;
                mem_err_next = 1'b1;
            end
            default: begin
                state_next    = IDLE;
                wait_cnt_next = '0;
            end
        endcase
    end

    // State register of the memory wait tracker. Reset returns it to IDLE
    // from any state, including mid-wait and ERROR, and clears the fault.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_cnt_next;
            mem_err_q <= mem_err_next;
        end
    end

    // Pipeline control outputs in priority order: reset, latched fault,
    // memory wait, then normal hazards. A fault or a memory wait freezes
    // every stage and bubbles Writeback so no instruction retires twice.
    // Decode and Execute are not flushed while frozen, so a pending branch
    // or load-use in Execute takes effect in the first cycle after release.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (reset) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if ((state == ERROR) || mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = lw_stall;
            StallD = lw_stall;
            FlushD = PCSrcE;
            FlushE = lw_stall | PCSrcE;
        end
    end

    // Event qualifiers for the performance counters. A control flush counts
    // only when the branch really flushes Decode, not during reset or while
    // the pipeline is frozen.
    always_comb begin
        any_stall    = StallF | StallD | StallE | StallM;
        branch_flush = FlushD && !reset;
    end

    // Performance counters. They saturate at all-ones rather than wrapping,
    // so a large reading is never mistaken for a small one.
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCycles <= '0;
            FlushCount  <= '0;
        end else begin
            if (any_stall && (StallCycles != CNT_MAX)) begin
                StallCycles <= StallCycles + CNT_W'(1);
            end
            if (branch_flush && (FlushCount != CNT_MAX)) begin
                FlushCount <= FlushCount + CNT_W'(1);
            end
        end
    end

    // The fault flag seen by software is the latched fault bit.
    always_comb begin
        MemErr = mem_err_q;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. A table of single-cycle vectors
// covers forwarding and the combinational stall/flush decisions. The
// sequences after it cover reset, the counters, memory waits, the timeout
// fault and counter saturation. The counters are 4 bits wide here so that
// saturation is reachable in a short run.
module tb_hazard_ctrl;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 8;
    localparam int TO_W        = 4;

    logic             clk;
    logic             reset;
    logic [4:0]       rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0]       result_src_e;
    logic             reg_write_m, reg_write_w, pc_src_e, mem_req_m, mem_ack_m;
    logic [1:0]       forward_ae, forward_be;
    logic             stall_f, stall_d, stall_e, stall_m;
    logic             flush_d, flush_e, flush_w;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic [6:0]       ctrl;

    int checks;
    int failures;

    // One table entry: the inputs for one cycle and the outputs expected.
    // ctrl bits are {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}.
    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic [1:0] rsrc;
        logic       rwm, rww, pcs, mreq, mack;
        logic [1:0] exp_fa, exp_fb;
        logic [6:0] exp_ctrl;
    } vec_t;

    vec_t vecs[15];

    hazard_ctrl #(
        .CNT_W      (CNT_W),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TO_W       (TO_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Rs1D       (rs1_d),
        .Rs2D       (rs2_d),
        .Rs1E       (rs1_e),
        .Rs2E       (rs2_e),
        .RdE        (rd_e),
        .RdM        (rd_m),
        .RdW        (rd_w),
        .ResultSrcE (result_src_e),
        .RegWriteM  (reg_write_m),
        .RegWriteW  (reg_write_w),
        .PCSrcE     (pc_src_e),
        .MemReqM    (mem_req_m),
        .MemAckM    (mem_ack_m),
        .ForwardAE  (forward_ae),
        .ForwardBE  (forward_be),
        .StallF     (stall_f),
        .StallD     (stall_d),
        .StallE     (stall_e),
        .StallM     (stall_m),
        .FlushD     (flush_d),
        .FlushE     (flush_e),
        .FlushW     (flush_w),
        .MemErr     (mem_err),
        .StallCycles(stall_cycles),
        .FlushCount (flush_count)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign ctrl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};

    function automatic vec_t make_vec(
        input logic [4:0] rs1d, input logic [4:0] rs2d,
        input logic [4:0] rs1e, input logic [4:0] rs2e,
        input logic [4:0] rde,  input logic [4:0] rdm, input logic [4:0] rdw,
        input logic [1:0] rsrc, input logic rwm, input logic rww,
        input logic pcs, input logic mreq, input logic mack,
        input logic [1:0] efa, input logic [1:0] efb, input logic [6:0] ectrl);
        vec_t v;
        v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
        v.rde = rde; v.rdm = rdm; v.rdw = rdw; v.rsrc = rsrc;
        v.rwm = rwm; v.rww = rww; v.pcs = pcs; v.mreq = mreq; v.mack = mack;
        v.exp_fa = efa; v.exp_fb = efb; v.exp_ctrl = ectrl;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic idleInputs();
        rs1_d = 5'd0; rs2_d = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0;
        rd_e = 5'd0; rd_m = 5'd0; rd_w = 5'd0; result_src_e = 2'b00;
        reg_write_m = 1'b0; reg_write_w = 1'b0; pc_src_e = 1'b0;
        mem_req_m = 1'b0; mem_ack_m = 1'b0;
    endtask

    // Drives one table entry at the falling edge and settles before sampling.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rs1_d = v.rs1d; rs2_d = v.rs2d; rs1_e = v.rs1e; rs2_e = v.rs2e;
        rd_e = v.rde; rd_m = v.rdm; rd_w = v.rdw; result_src_e = v.rsrc;
        reg_write_m = v.rwm; reg_write_w = v.rww; pc_src_e = v.pcs;
        mem_req_m = v.mreq; mem_ack_m = v.mack;
        #2;
    endtask

    // One reset edge with idle inputs, then release at the next falling edge.
    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        idleInputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Falling-edge step that idles all inputs, ready for the caller to override.
    task automatic stepIdle();
        @(negedge clk);
        idleInputs();
    endtask

    task automatic driveLoadUse();
        result_src_e = 2'b01; rd_e = 5'd3; rs1_d = 5'd3;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        idleInputs();

        // Reset outputs with hazards present on every input group.
        @(negedge clk);
        reset = 1'b1;
        reg_write_m = 1'b1; rd_m = 5'd5; rs1_e = 5'd5; rs2_e = 5'd5;
        driveLoadUse();
        pc_src_e = 1'b1;
        #2;
        checkOutput("reset_fwd_a", 32'(forward_ae), 32'(2'b00));
        checkOutput("reset_fwd_b", 32'(forward_be), 32'(2'b00));
        checkOutput("reset_ctrl", 32'(ctrl), 32'(7'b0000111));
        stepIdle();
        reset = 1'b0;
        #2;
        checkOutput("reset_stall_cycles", 32'(stall_cycles), 32'd0);
        checkOutput("reset_flush_count", 32'(flush_count), 32'd0);
        checkOutput("reset_mem_err", 32'(mem_err), 32'd0);

        // Single-cycle table: rs1d rs2d rs1e rs2e rde rdm rdw rsrc rwm rww pcs mreq mack | fa fb ctrl
        vecs[0]  = make_vec(0,0,5,0,0,5,5,2'b00,1,1,0,0,0, 2'b10,2'b00,7'b0000000);
        vecs[1]  = make_vec(0,0,5,0,0,5,5,2'b00,0,1,0,0,0, 2'b01,2'b00,7'b0000000);
        vecs[2]  = make_vec(0,0,0,0,0,5,0,2'b00,0,1,0,0,0, 2'b00,2'b00,7'b0000000);
        vecs[3]  = make_vec(0,0,9,7,0,7,9,2'b00,1,1,0,0,0, 2'b01,2'b10,7'b0000000);
        vecs[4]  = make_vec(0,0,0,0,0,0,0,2'b00,1,1,0,0,0, 2'b00,2'b00,7'b0000000);
        vecs[5]  = make_vec(0,3,0,0,3,0,0,2'b01,0,0,0,0,0, 2'b00,2'b00,7'b1100010);
        vecs[6]  = make_vec(0,0,0,0,0,0,0,2'b01,0,0,0,0,0, 2'b00,2'b00,7'b0000000);
        vecs[7]  = make_vec(3,0,0,0,3,0,0,2'b00,0,0,0,0,0, 2'b00,2'b00,7'b0000000);
        vecs[8]  = make_vec(4,0,0,0,4,0,0,2'b01,0,0,0,0,0, 2'b00,2'b00,7'b1100010);
        vecs[9]  = make_vec(0,0,0,0,0,0,0,2'b00,0,0,1,0,0, 2'b00,2'b00,7'b0000110);
        vecs[10] = make_vec(4,0,0,0,4,0,0,2'b01,0,0,1,0,0, 2'b00,2'b00,7'b1100110);
        vecs[11] = make_vec(0,0,0,0,0,0,0,2'b00,0,0,0,1,1, 2'b00,2'b00,7'b0000000);
        vecs[12] = make_vec(4,0,0,0,4,0,0,2'b01,0,0,1,1,0, 2'b00,2'b00,7'b1111001);
        vecs[13] = make_vec(0,0,0,0,0,0,0,2'b00,0,0,0,0,0, 2'b00,2'b00,7'b0000000);
        vecs[14] = make_vec(0,0,6,6,0,6,6,2'b00,0,0,0,0,0, 2'b00,2'b00,7'b0000000);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_fwd_a", i), 32'(forward_ae), 32'(vecs[i].exp_fa));
            checkOutput($sformatf("vec%0d_fwd_b", i), 32'(forward_be), 32'(vecs[i].exp_fb));
            checkOutput($sformatf("vec%0d_ctrl", i), 32'(ctrl), 32'(vecs[i].exp_ctrl));
        end

        // One load-use cycle adds exactly one stall cycle and no flush count.
        doReset();
        stepIdle();
        result_src_e = 2'b01; rd_e = 5'd3; rs2_d = 5'd3;
        #2;
        checkOutput("lw_ctrl", 32'(ctrl), 32'(7'b1100010));
        checkOutput("lw_stall_cycles_before", 32'(stall_cycles), 32'd0);
        stepIdle();
        #2;
        checkOutput("lw_stall_cycles_after", 32'(stall_cycles), 32'd1);
        checkOutput("lw_flush_count", 32'(flush_count), 32'd0);

        // One taken branch adds one flush count and no stall cycles.
        doReset();
        stepIdle();
        pc_src_e = 1'b1;
        #2;
        checkOutput("br_ctrl", 32'(ctrl), 32'(7'b0000110));
        checkOutput("br_flush_count_before", 32'(flush_count), 32'd0);
        stepIdle();
        #2;
        checkOutput("br_flush_count_after", 32'(flush_count), 32'd1);
        checkOutput("br_stall_cycles", 32'(stall_cycles), 32'd0);

        // Three wait states with a branch pending in Execute. The flush
        // fires only in the acknowledge cycle.
        doReset();
        for (int i = 0; i < 3; i++) begin
            stepIdle();
            mem_req_m = 1'b1; pc_src_e = 1'b1;
            #2;
            checkOutput($sformatf("wait%0d_ctrl", i), 32'(ctrl), 32'(7'b1111001));
        end
        stepIdle();
        mem_req_m = 1'b1; mem_ack_m = 1'b1; pc_src_e = 1'b1;
        #2;
        checkOutput("wait_ack_ctrl", 32'(ctrl), 32'(7'b0000110));
        stepIdle();
        #2;
        checkOutput("wait_stall_cycles", 32'(stall_cycles), 32'd3);
        checkOutput("wait_flush_count", 32'(flush_count), 32'd1);
        checkOutput("wait_mem_err", 32'(mem_err), 32'd0);
        checkOutput("wait_idle_ctrl", 32'(ctrl), 32'(7'b0000000));

        // Acknowledge on the eighth stalled cycle avoids the fault.
        doReset();
        for (int i = 0; i < 7; i++) begin
            stepIdle();
            mem_req_m = 1'b1;
        end
        stepIdle();
        mem_req_m = 1'b1; mem_ack_m = 1'b1;
        #2;
        checkOutput("late_ack_ctrl", 32'(ctrl), 32'(7'b0000000));
        stepIdle();
        #2;
        checkOutput("late_ack_mem_err", 32'(mem_err), 32'd0);
        checkOutput("late_ack_stall_cycles", 32'(stall_cycles), 32'd7);
        stepIdle();
        mem_req_m = 1'b1;
        #2;
        checkOutput("late_ack_restall_ctrl", 32'(ctrl), 32'(7'b1111001));

        // No acknowledge: the fault latches after the eighth stalled edge
        // and keeps the pipeline frozen even without a memory request.
        doReset();
        for (int i = 0; i < 8; i++) begin
            stepIdle();
            mem_req_m = 1'b1;
            #2;
            checkOutput($sformatf("to%0d_mem_err", i), 32'(mem_err), 32'd0);
        end
        stepIdle();
        pc_src_e = 1'b1;
        driveLoadUse();
        #2;
        checkOutput("to_mem_err", 32'(mem_err), 32'd1);
        checkOutput("to_err_ctrl", 32'(ctrl), 32'(7'b1111001));
        checkOutput("to_stall_cycles", 32'(stall_cycles), 32'd8);
        stepIdle();
        #2;
        checkOutput("to_err_hold_ctrl", 32'(ctrl), 32'(7'b1111001));
        checkOutput("to_stall_cycles_hold", 32'(stall_cycles), 32'd9);
        checkOutput("to_flush_count", 32'(flush_count), 32'd0);

        // Reset taken from ERROR clears the fault and releases the stalls.
        stepIdle();
        reset = 1'b1;
        pc_src_e = 1'b1;
        #2;
        checkOutput("err_reset_ctrl", 32'(ctrl), 32'(7'b0000111));
        stepIdle();
        reset = 1'b0;
        #2;
        checkOutput("err_reset_mem_err", 32'(mem_err), 32'd0);
        checkOutput("err_reset_stall_cycles", 32'(stall_cycles), 32'd0);
        checkOutput("err_reset_ctrl_after", 32'(ctrl), 32'(7'b0000000));

        // Twenty load-use cycles saturate the 4-bit stall counter at 15.
        doReset();
        for (int i = 0; i < 20; i++) begin
            stepIdle();
            driveLoadUse();
        end
        stepIdle();
        #2;
        checkOutput("sat_stall_cycles", 32'(stall_cycles), 32'd15);
        stepIdle();
        driveLoadUse();
        stepIdle();
        #2;
        checkOutput("sat_stall_cycles_hold", 32'(stall_cycles), 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
